// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one lock-step pipelined signed W x W multiplier among NREQ requesters.
// Define MUL_SHARE_ARBITER_ASSERT_EN to compile in the concurrent checks and their shadow model.
module mul_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int LAT  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*W-1:0]         req_a,
  input  logic [NREQ*W-1:0]         req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic signed [2*W-1:0]     rsp_c
);

  localparam int IDW = $clog2(NREQ);

  logic                  advance;
  logic                  gnt_found;
  logic                  gnt_fire;
  logic [IDW-1:0]        gnt_idx;
  logic [IDW-1:0]        ptr;
  logic signed [W-1:0]   a_sel;
  logic signed [W-1:0]   b_sel;

  logic [LAT-1:0]        vld_p;
  logic [IDW-1:0]        id_p [LAT];
  logic signed [2*W-1:0] c_p  [LAT];

  function automatic logic signed [2*W-1:0] mul_full(input logic signed [W-1:0] a,
                                                     input logic signed [W-1:0] b);
    logic signed [2*W-1:0] ax;
    logic signed [2*W-1:0] bx;
    ax = a;
    bx = b;
    return ax * bx;
  endfunction

  // A stalled output stalls every stage, so issue is allowed exactly when the pipe moves.
  assign advance = !rsp_valid || rsp_ready;

  always_comb begin
    int j;
    j         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!gnt_found && req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(j);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && advance && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign gnt_fire = |req_ready;
  assign a_sel    = req_a[gnt_idx*W +: W];
  assign b_sel    = req_b[gnt_idx*W +: W];

  // Stage 0 takes the full product (or a bubble); later stages shift it toward the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      vld_p <= '0;
      for (int s = 0; s < LAT; s++) begin
        id_p[s] <= '0;
        c_p[s]  <= '0;
      end
    end else if (advance) begin
      vld_p[0] <= gnt_fire;
      id_p[0]  <= gnt_idx;
      c_p[0]   <= mul_full(a_sel, b_sel);
      for (int s = 1; s < LAT; s++) begin
        vld_p[s] <= vld_p[s-1];
        id_p[s]  <= id_p[s-1];
        c_p[s]   <= c_p[s-1];
      end
      if (gnt_fire) ptr <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign rsp_valid = vld_p[LAT-1];
  assign rsp_id    = id_p[LAT-1];
  assign rsp_c     = c_p[LAT-1];

`ifdef MUL_SHARE_ARBITER_ASSERT_EN
  logic [W-1:0] sh_a [LAT];
  logic [W-1:0] sh_b [LAT];
  int           wait_cnt [NREQ];

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    return {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
  endfunction

  always_ff @(posedge clk) begin
    if (advance) begin
      sh_a[0] <= req_a[gnt_idx*W +: W];
      sh_b[0] <= req_b[gnt_idx*W +: W];
      for (int s = 1; s < LAT; s++) begin
        sh_a[s] <= sh_a[s-1];
        sh_b[s] <= sh_b[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) wait_cnt[i] <= 0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || req_ready[i]) wait_cnt[i] <= 0;
        else if (advance)                  wait_cnt[i] <= wait_cnt[i] + 1;
      end
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
  a_stable: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid && !rsp_ready |=> rsp_valid && $stable(rsp_id) && $stable(rsp_c));
  a_prod:   assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid |-> rsp_c == ref_mul(sh_a[LAT-1], sh_b[LAT-1]));
  a_id:     assert property (@(posedge clk) disable iff (!rst_n) int'(rsp_id) < NREQ);

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_fair
    a_fair: assert property (@(posedge clk) disable iff (!rst_n) wait_cnt[gi] < NREQ);
  end
`endif

endmodule
